lsu_align_fsm: RTL and testbench

//  Sequential load/store unit between the SRM core datapath and the data memory port.

---
 rtl/lsu_align_fsm.sv | 215 +++++++++++++++++++++
 tb/tb_lsu_align_fsm.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align_fsm.sv
`default_nettype none
// ============================================================================
// lsu_align_fsm - sequential big-endian load/store unit with read-modify-write
// partial stores. Option macro: LSU_MISALIGN_TRAP_EN. Rev 1.0
// ============================================================================
module lsu_align_fsm #(
  parameter int XLEN    = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [AW-1:0]   req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_fault,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [XLEN-1:0] mem_dout,
  input  logic [XLEN-1:0] mem_din,
  input  logic            mem_ack
);
  localparam int          OFFW = $clog2(XLEN / 8);
  localparam logic [7:0]  NB   = 8'(XLEN / 8);
  localparam logic [31:0] TO   = 32'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RSP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_fault_q, rsp_fault_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [OFFW-1:0] off_q, off_d;
  logic [1:0]      size_q, size_d;
  logic            sgn_q, sgn_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [XLEN-1:0] dout_q, dout_d;
  logic [31:0]     cnt_q, cnt_d;

  logic [7:0]      a_bytes, a_off;
  logic            a_illegal, a_mis, a_full;
  logic [7:0]      l_bits, l_shift;
  logic [XLEN-1:0] l_mask, l_lane, l_ext, l_merge;
  logic            l_msb, expire;

  always_comb begin
    a_bytes   = 8'd1 << req_size;
    a_off     = 8'(req_addr[OFFW-1:0]);
    a_illegal = (XLEN == 32) && (req_size == 2'b11);
    a_full    = (a_bytes == NB);
`ifdef LSU_MISALIGN_TRAP_EN
    a_mis     = (a_off & (a_bytes - 8'd1)) != 8'd0;
`else
    a_mis     = 1'b0;
`endif
  end

  // Lane 0 sits at the MSB end, so the shift counts down from the top byte.
  always_comb begin
    l_bits  = 8'd8 << size_q;
    l_shift = (NB - 8'(off_q) - (8'd1 << size_q)) << 3;
    l_mask  = ~({XLEN{1'b1}} << l_bits);
    l_lane  = (mem_din >> l_shift) & l_mask;
    l_msb   = |(l_lane & (l_mask ^ (l_mask >> 1)));
    l_ext   = (sgn_q && l_msb) ? (l_lane | ~l_mask) : l_lane;
    l_merge = (mem_din & ~(l_mask << l_shift)) | ((wdata_q & l_mask) << l_shift);
    expire  = (TIMEOUT != 0) && ((cnt_q + 32'd1) >= TO);
  end

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_fault_d = rsp_fault_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    addr_d      = addr_q;
    off_d       = off_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    dout_d      = dout_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d      = {req_addr[AW-1:OFFW], {OFFW{1'b0}}};
          off_d       = OFFW'(a_off & ~(a_bytes - 8'd1));
          size_d      = req_size;
          sgn_d       = req_signed;
          we_d        = req_we;
          wdata_d     = req_wdata;
          cnt_d       = '0;
          rdata_d     = '0;
          rsp_fault_d = 1'b0;
          if (a_illegal || a_mis) begin
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
          end else if (req_we && a_full) begin
            state_d   = S_WR;
            mem_req_d = 1'b1;
            mem_we_d  = 1'b1;
            dout_d    = req_wdata;
          end else begin
            state_d   = S_RD;
            mem_req_d = 1'b1;
            mem_we_d  = 1'b0;
          end
        end
      end
      S_RD, S_WR: begin
        if (mem_ack) begin
          cnt_d = '0;
          if (state_q == S_RD && we_q) begin
            // Partial store: merge now, keep mem_req high into the write phase.
            dout_d   = l_merge;
            mem_we_d = 1'b1;
            state_d  = S_WR;
          end else begin
            rdata_d     = (state_q == S_RD) ? l_ext : '0;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = S_RSP;
          end
        end else begin
          if (TIMEOUT != 0) cnt_d = cnt_q + 32'd1;
          if (expire) begin
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
            rdata_d     = '0;
            state_d     = S_RSP;
          end
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      addr_q      <= '0;
      off_q       <= '0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      dout_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      addr_q      <= addr_d;
      off_q       <= off_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      dout_q      <= dout_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_rdata = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_dout  = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_align_fsm.sv
`default_nettype none
// tb_lsu_align_fsm: scoreboard bench, random traffic against a word-array memory model.
module tb_lsu_align_fsm;
  localparam int XLEN = 32;
  localparam int AW = 32;
  localparam int TIMEOUT = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            req_valid, req_ready, req_we, req_signed;
  logic [1:0]      req_size;
  logic [AW-1:0]   req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid, rsp_ready, rsp_fault;
  logic [XLEN-1:0] rsp_rdata;
  logic            mem_req, mem_we, mem_ack;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_dout, mem_din;

  always #5 clk = ~clk;

  lsu_align_fsm #(.XLEN(XLEN), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ack(mem_ack)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          nrd;
    int          nwr;
  } exp_t;

  int          vectors = 0;
  int          miscompares = 0;
  exp_t        sbq[$];
  logic [31:0] mem_arr[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  int          nrd_seen = 0;
  int          nwr_seen = 0;
  int          req_cycles = 0;
  bit          hold_off = 1'b0;
  int          fixed_delay = -1;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] mem_get(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic exp_t mk(input logic [31:0] r, input logic f, input int nr, input int nw);
    exp_t e;
    e.rdata = r; e.fault = f; e.nrd = nr; e.nwr = nw;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: memory as an array of big-endian words, lanes picked by byte arithmetic.
  task automatic model(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd, output exp_t e);
    int bytes, off, sh;
    longint unsigned word, lane, m;
    logic [31:0] base;
    bytes = 1 << sz;
    off = int'(addr % 4);
    base = addr - 32'(off);
    e = mk(32'h0, 1'b0, 0, 0);
    if (bytes > 4) begin e.fault = 1'b1; return; end
`ifdef LSU_MISALIGN_TRAP_EN
    if (off % bytes != 0) begin e.fault = 1'b1; return; end
`else
    off = off - off % bytes;
`endif
    word = 64'(ref_get(base));
    sh = 8 * (4 - off - bytes);
    m = (64'd1 << (8 * bytes)) - 64'd1;
    if (!we) begin
      lane = (word >> sh) & m;
      if (sgn && lane[8*bytes-1]) lane = lane | ~m;
      e.rdata = lane[31:0];
      e.nrd = 1;
    end else if (bytes == 4) begin
      ref_mem[base] = wd;
      e.nwr = 1;
    end else begin
      ref_mem[base] = 32'((word & ~(m << sh)) | ((64'(wd) & m) << sh));
      e.nrd = 1;
      e.nwr = 1;
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input bit use_exp, input exp_t xe);
    exp_t e;
    int n;
    model(we, sz, sgn, addr, wd, e);
    if (use_exp) e = xe;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 400) begin @(negedge clk); n++; end
    if (!req_ready) begin
      vectors++; miscompares++;
      $display("FAIL accept_wait: req_ready got 0 expected 1");
      return;
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
    req_addr = addr; req_wdata = wd;
    sbq.push_back(e);
    @(posedge clk); #1;
    if ($urandom_range(0, 3) == 0) begin
      req_we = 1'($urandom); req_size = 2'($urandom_range(0, 2));
      req_addr = $urandom; req_wdata = $urandom;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 600) begin @(negedge clk); n++; end
    if (sbq.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL drain_wait: pending got %0d expected 0", sbq.size());
      sbq.delete();
    end
    @(posedge clk); #1;
  endtask

  // Memory responder
  initial begin
    int wait_left;
    wait_left = -1;
    mem_ack = 1'b0;
    mem_din = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      mem_din = $urandom;
      if (mem_req) req_cycles++;
      if (mem_req && !hold_off && rst_n) begin
        if (wait_left < 0)
          wait_left = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
        if (wait_left == 0) begin
          check("mem_addr_align", 64'(mem_addr[1:0]), 64'd0);
          if (mem_we) begin
            mem_arr[mem_addr] = mem_dout;
            nwr_seen++;
          end else begin
            mem_din = mem_get(mem_addr);
            nrd_seen++;
          end
          mem_ack = 1'b1;
          wait_left = -1;
        end else begin
          wait_left--;
        end
      end else begin
        wait_left = -1;
      end
    end
  end

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Response monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL spurious_rsp: rsp_valid got 1 expected 0");
        end else begin
          e = sbq.pop_front();
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check("rsp_fault", 64'(rsp_fault), 64'(e.fault));
          check("read_phases", 64'(nrd_seen), 64'(e.nrd));
          check("write_phases", 64'(nwr_seen), 64'(e.nwr));
        end
        nrd_seen = 0;
        nwr_seen = 0;
      end
    end
  end

  initial begin
    exp_t none;
    none = mk(32'h0, 1'b0, 0, 0);
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_fault", 64'(rsp_fault), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_dout", 64'(mem_dout), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    mem_arr[32'h100] = 32'h1122_3344; ref_mem[32'h100] = 32'h1122_3344;
    mem_arr[32'h200] = 32'hDEAD_BEEF; ref_mem[32'h200] = 32'hDEAD_BEEF;

    issue(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 1'b1, mk(32'h0000_0022, 1'b0, 1, 0));
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 1'b1, mk(32'h0, 1'b1, 0, 0));
`else
    issue(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 1'b1, mk(32'h0000_1122, 1'b0, 1, 0));
`endif
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'h1122_F00D, 1'b0, none);
    issue(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 1'b1, mk(32'hFFFF_F00D, 1'b0, 1, 0));
    issue(1'b1, 2'b00, 1'b0, 32'h203, 32'h0000_00AB, 1'b1, mk(32'h0, 1'b0, 1, 1));
    issue(1'b1, 2'b10, 1'b0, 32'h300, 32'hCAFE_BABE, 1'b1, mk(32'h0, 1'b0, 0, 1));
    issue(1'b0, 2'b11, 1'b1, 32'h104, 32'h0, 1'b1, mk(32'h0, 1'b1, 0, 0));
    drain();
    check("merge_0x200", 64'(mem_get(32'h200)), 64'hDEAD_BEAB);
    check("store_0x300", 64'(mem_get(32'h300)), 64'hCAFE_BABE);

    // Watchdog expiry with no ack ever.
    hold_off = 1'b1;
    req_cycles = 0;
    issue(1'b0, 2'b10, 1'b0, 32'h204, 32'h0, 1'b1, mk(32'h0, 1'b1, 0, 0));
    drain();
    check("timeout_req_cycles", 64'(req_cycles), 64'd8);
    hold_off = 1'b0;

    // Ack in the same cycle the watchdog would expire.
    fixed_delay = 7;
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b0, none);
    drain();
    fixed_delay = -1;

    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
            32'h400 + 32'($urandom_range(0, 63)), $urandom, 1'b0, none);
    end
    drain();

    foreach (ref_mem[k]) check($sformatf("mem_%0h", k), 64'(mem_get(k)), 64'(ref_mem[k]));
    foreach (mem_arr[k]) check($sformatf("dut_mem_%0h", k), 64'(mem_arr[k]), 64'(ref_get(k)));

    // Asynchronous reset in the middle of a read phase.
    hold_off = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h404;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid_rd_mem_req", 64'(mem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_req", 64'(mem_req), 64'd0);
    check("async_rst_req_ready", 64'(req_ready), 64'd1);
    check("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    hold_off = 1'b0;
    nrd_seen = 0;
    nwr_seen = 0;

    issue(1'b0, 2'b00, 1'b1, 32'h200, 32'h0, 1'b1, mk(32'hFFFF_FFDE, 1'b0, 1, 0));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
